acc_drain_seq: RTL

Sequencer that drains a captured vector of N_ACC signed 18-bit accumulators through a single shared int18_to_bf16_lzd converter, one element per cycle, onto a valid/ready bf16 output stream. It sits between the systolic array's accumulator bank and the result writeback path, and time-multiplexes one converter instead of instantiating N_ACC of them.

---
 rtl/tpu_pkg.sv | 18 +
 rtl/int18_to_bf16_lzd.sv | 56 +++++
 rtl/acc_drain_seq.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/tpu_pkg.sv
// Shared definitions for the accumulator drain path.
//   ACC_W        : accumulator width (signed two's complement)
//   BF16_W       : bf16 word width
//   BF16_EXP_MAX : all-ones bf16 exponent (infinity / NaN encoding)
//   drain_state_e: drain sequencer FSM states
package tpu_pkg;

  localparam int ACC_W = 18;
  localparam int BF16_W = 16;
  localparam logic [7:0] BF16_EXP_MAX = 8'hFF;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    FIN   = 2'd2
  } drain_state_e;

endpackage

// File: rtl/int18_to_bf16_lzd.sv
// Combinational signed 18-bit fixed-point to bf16 converter.
// The input is interpreted as acc / 2**FRAC_BITS. Zero maps to +0, an
// exponent that would underflow flushes to signed zero, one that would
// overflow saturates to signed infinity, and the mantissa is truncated.
// Ports:
//   acc  in  ACC_W   signed fixed-point value
//   bf16 out BF16_W  converted bf16 word
module int18_to_bf16_lzd
  import tpu_pkg::*;
#(
  parameter int FRAC_BITS = 8
) (
  input  logic [ACC_W-1:0]  acc,
  output logic [BF16_W-1:0] bf16
);

  // lzd18: bit position of the leading one (0 when v is zero; caller
  // handles the zero case separately).
  function automatic logic [4:0] lzd18(input logic [17:0] v);
    logic [4:0] pos;
    pos = 5'd0;
    for (int i = 0; i < 18; i++) begin
      if (v[i]) begin
        pos = 5'(i);
      end
    end
    return pos;
  endfunction

  logic        sign_s;
  logic [17:0] mag_s;
  logic [4:0]  pos_s;
  logic [6:0]  mant_s;
  int          exp_s;

  // Sign/magnitude split, normalisation and exponent/mantissa packing.
  always_comb begin
    sign_s = acc[ACC_W-1];
    // -131072 negates to 18'h20000, which is the correct unsigned magnitude.
    mag_s  = sign_s ? (~acc + 18'd1) : acc;
    pos_s  = lzd18(mag_s);
    exp_s  = int'(pos_s) - FRAC_BITS + 32'sd127;
    // Move the leading one to bit 17, keep the 7 bits below it (truncate).
    mant_s = 7'((mag_s << (5'd17 - pos_s)) >> 10);
    if (mag_s == 18'd0) begin
      bf16 = 16'h0000;
    end else if (exp_s >= 32'sd255) begin
      bf16 = {sign_s, BF16_EXP_MAX, 7'd0};
    end else if (exp_s <= 32'sd0) begin
      bf16 = {sign_s, 15'd0};
    end else begin
      bf16 = {sign_s, 8'(exp_s), mant_s};
    end
  end

endmodule

// File: rtl/acc_drain_seq.sv
// Drains a captured vector of N_ACC signed 18-bit accumulators through one
// shared int18_to_bf16_lzd converter onto a valid/ready bf16 stream, one
// element per cycle.
// Ports:
//   clk, rst_n  clock, async active-low reset
//   start       capture acc_in and begin a drain (IDLE only)
//   abort       synchronous flush to IDLE
//   acc_in      packed accumulators, element k at [18k+17:18k]
//   busy        high whenever not IDLE
//   out_valid / out_ready  output handshake
//   out_data, out_idx, out_last, out_inf  output word and sideband
//   done        one-cycle pulse after the last word is accepted
module acc_drain_seq
  import tpu_pkg::*;
#(
  parameter  int N_ACC     = 4,
  parameter  int FRAC_BITS = 8,
  localparam int IDX_W     = $clog2(N_ACC)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  input  logic [ACC_W*N_ACC-1:0] acc_in,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BF16_W-1:0]      out_data,
  output logic [IDX_W-1:0]       out_idx,
  output logic                   out_last,
  output logic                   out_inf,
  output logic                   done
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ACC - 1);
  localparam logic [IDX_W:0]   CNT_N    = (IDX_W + 1)'(N_ACC);

  drain_state_e      state_r;
  logic [ACC_W-1:0]  acc_buf_r [N_ACC];
  logic [IDX_W-1:0]  rd_ptr_r;
  logic [IDX_W:0]    cnt_r;
  logic [BF16_W-1:0] conv_s;
  logic              load_s;
  logic              capture_s;

  int18_to_bf16_lzd #(
    .FRAC_BITS(FRAC_BITS)
  ) u_conv (
    .acc (acc_buf_r[rd_ptr_r]),
    .bf16(conv_s)
  );

  // Load/capture qualifiers: abort masks any capture in the same cycle.
  always_comb begin
    load_s    = 1'b0;
    capture_s = 1'b0;
    if (state_r == DRAIN) begin
      load_s = (!out_valid || out_ready) && (cnt_r < CNT_N);
    end else begin
      load_s = 1'b0;
    end
    if ((state_r == IDLE) && start && !abort) begin
      capture_s = 1'b1;
    end else begin
      capture_s = 1'b0;
    end
  end

  // Accumulator snapshot; held across abort, only rewritten on capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_ACC; k++) begin
        acc_buf_r[k] <= '0;
      end
    end else if (capture_s) begin
      for (int k = 0; k < N_ACC; k++) begin
        acc_buf_r[k] <= acc_in[ACC_W*k +: ACC_W];
      end
    end
  end

  // Drain FSM with the inline output register stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= IDLE;
      rd_ptr_r  <= '0;
      cnt_r     <= '0;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 16'h0000;
      out_idx   <= '0;
      out_last  <= 1'b0;
      out_inf   <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      // A word shown this cycle is dropped, not accepted.
      state_r   <= IDLE;
      busy      <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            rd_ptr_r <= '0;
            cnt_r    <= '0;
            busy     <= 1'b1;
            state_r  <= DRAIN;
          end
        end
        DRAIN: begin
          if (load_s) begin
            out_data  <= conv_s;
            out_idx   <= rd_ptr_r;
            out_last  <= (rd_ptr_r == LAST_IDX);
            out_inf   <= (conv_s[14:7] == BF16_EXP_MAX);
            out_valid <= 1'b1;
            cnt_r     <= cnt_r + 1'b1;
            if (rd_ptr_r != LAST_IDX) begin
              rd_ptr_r <= rd_ptr_r + 1'b1;
            end
          end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            if (out_last) begin
              done    <= 1'b1;
              state_r <= FIN;
            end
          end
        end
        FIN: begin
          out_data <= 16'h0000;
          out_idx  <= '0;
          out_last <= 1'b0;
          out_inf  <= 1'b0;
          done     <= 1'b0;
          busy     <= 1'b0;
          state_r  <= IDLE;
        end
        default: begin
          out_valid <= 1'b0;
          done      <= 1'b0;
          busy      <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule
